// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: host bus (start/a/b/bin to block, busy/done/diff/bout[/ovf with SERIAL_SUB_SIGNED_EN] back), master=host, slave=subtractor
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic start, bin, busy, done, bout;
  logic [WIDTH-1:0] a, b, diff;
`ifdef SERIAL_SUB_SIGNED_EN
  logic ovf;
  modport master(output start, a, b, bin, input busy, done, diff, bout, ovf);
  modport slave(input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
  modport master(output start, a, b, bin, input busy, done, diff, bout);
  modport slave(input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a-b-bin LSB first via one full-subtractor cell + borrow flop; ports clk, rst (sync high), bus (slave: start/a/b/bin in, busy/done/diff/bout out, ovf when SERIAL_SUB_SIGNED_EN defined)
module serial_subtractor #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  serial_subtractor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int CW = $clog2(WIDTH);
  state_t r_state, w_state_n;
  logic [WIDTH-1:0] r_sa, r_sb, r_diff;
  logic [CW-1:0] r_cnt;
  logic r_br, r_bout, w_d, w_br_n, w_last;
  assign w_d = r_sa[0] ^ r_sb[0] ^ r_br;
  assign w_br_n = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
  assign w_last = r_cnt == CW'(WIDTH - 1);
  always_comb begin
    w_state_n = r_state == IDLE ? (bus.start ? RUN : IDLE) : r_state == RUN ? (w_last ? DONE : RUN) : IDLE;
    bus.busy = r_state != IDLE;
    bus.done = r_state == DONE;
  end
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_state_n;
`ifdef SERIAL_SUB_SIGNED_EN
  logic r_ovf;
  assign bus.ovf = r_ovf;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      r_sa <= '0;
      r_sb <= '0;
      r_br <= 1'b0;
      r_cnt <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_EN
      r_ovf <= 1'b0;
`endif
    end else if (r_state == IDLE && bus.start) begin
      r_sa <= bus.a;
      r_sb <= bus.b;
      r_br <= bus.bin;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_diff <= {w_d, r_diff[WIDTH-1:1]};
      r_sa <= r_sa >> 1;
      r_sb <= r_sb >> 1;
      r_br <= w_br_n;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_bout <= w_br_n;
`ifdef SERIAL_SUB_SIGNED_EN
        r_ovf <= (r_sa[0] ^ r_sb[0]) & (w_d ^ r_sa[0]);
`endif
      end
    end
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed self-checking bench for serial_subtractor at WIDTH=8
module tb_serial_subtractor;
  logic clk = 1'b0, rst = 1'b1;
  int tests = 0, fails = 0;
  serial_subtractor_if #(.WIDTH(8)) bus();
  serial_subtractor #(.WIDTH(8)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                       output logic [7:0] od, output logic obo, output int lat, output int bc, output logic pulse_ok);
    bus.a = ia;
    bus.b = ib;
    bus.bin = ibin;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    lat = 0;
    bc = int'(bus.busy);
    while (!bus.done && lat < 40) begin
      tick;
      lat++;
      bc += int'(bus.busy);
    end
    od = bus.diff;
    obo = bus.bout;
    tick;
    pulse_ok = !bus.done && !bus.busy && bus.diff == od;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b1;
    bus.a = 8'h12;
    bus.b = 8'h34;
    bus.bin = 1'b0;
    tick;
    tick;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", bus.done); end
    tests++; if (bus.diff !== 8'h00) begin fails++; $display("FAIL reset_diff: got %h want 00", bus.diff); end
    tests++; if (bus.bout !== 1'b0) begin fails++; $display("FAIL reset_bout: got %b want 0", bus.bout); end
    bus.start = 1'b0;
    rst = 1'b0;
    tick;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_idle: got busy %b want 0", bus.busy); end
  endtask
  task automatic test_basic;
    logic [7:0] d; logic bo, ok; int lat, bc;
    do_op(8'h05, 8'h03, 1'b0, d, bo, lat, bc, ok);
    tests++; if (lat != 8) begin fails++; $display("FAIL basic_latency: got %0d want 8", lat); end
    tests++; if (bc != 9) begin fails++; $display("FAIL basic_busy_cycles: got %0d want 9", bc); end
    tests++; if (d !== 8'h02) begin fails++; $display("FAIL basic_diff: got %h want 02", d); end
    tests++; if (bo !== 1'b0) begin fails++; $display("FAIL basic_bout: got %b want 0", bo); end
    tests++; if (!ok) begin fails++; $display("FAIL basic_done_pulse: got done %b busy %b want 0 0", bus.done, bus.busy); end
  endtask
  task automatic test_vectors;
    logic [7:0] va [6] = '{8'h03, 8'h00, 8'hA5, 8'h3C, 8'hFF, 8'h00};
    logic [7:0] vb [6] = '{8'h05, 8'h00, 8'h00, 8'h3C, 8'h01, 8'hFF};
    logic vi [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] vd [6] = '{8'hFE, 8'hFF, 8'hA5, 8'hFF, 8'hFD, 8'h01};
    logic vo [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] d; logic bo, ok; int lat, bc;
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], vb[i], vi[i], d, bo, lat, bc, ok);
      tests++; if (d !== vd[i] || bo !== vo[i]) begin fails++; $display("FAIL vector_%0d: got %h/%b want %h/%b", i, d, bo, vd[i], vo[i]); end
    end
  endtask
  task automatic test_sweep;
    logic [7:0] v [8] = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};
    logic [7:0] d; logic bo, ok; int lat, bc, e;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        for (int k = 0; k < 2; k++) begin
          do_op(v[i], v[j], k[0], d, bo, lat, bc, ok);
          e = int'(v[i]) - int'(v[j]) - k;
          tests++; if (d !== e[7:0] || bo !== (e < 0)) begin fails++; $display("FAIL sweep %h-%h-%0d: got %h/%b want %h/%b", v[i], v[j], k, d, bo, e[7:0], e < 0); end
          tests++; if (lat != 8 || !ok) begin fails++; $display("FAIL sweep_timing %h-%h-%0d: got lat %0d pulse_ok %b want 8 1", v[i], v[j], k, lat, ok); end
        end
  endtask
  task automatic test_start_held;
    int ndone = 0;
    bus.a = 8'h10;
    bus.b = 8'h01;
    bus.bin = 1'b0;
    bus.start = 1'b1;
    tick;
    for (int c = 1; c <= 19; c++) begin
      tick;
      if (bus.done) begin
        ndone++;
        if (ndone == 1) begin
          tests++; if (c != 8 || bus.diff !== 8'h0F) begin fails++; $display("FAIL held_first: got cycle %0d diff %h want 8 0f", c, bus.diff); end
        end else begin
          tests++; if (c != 18 || bus.diff !== 8'h28) begin fails++; $display("FAIL held_second: got cycle %0d diff %h want 18 28", c, bus.diff); end
        end
      end
      bus.a = 8'h20 + 8'(c);
    end
    bus.start = 1'b0;
    tests++; if (ndone != 2) begin fails++; $display("FAIL held_count: got %0d done pulses want 2", ndone); end
    tick;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL held_idle: got busy %b want 0", bus.busy); end
  endtask
  task automatic test_abort;
    logic [7:0] d; logic bo, ok; int lat, bc, seen = 0;
    do_op(8'h00, 8'h01, 1'b0, d, bo, lat, bc, ok);
    bus.a = 8'hAA;
    bus.b = 8'h55;
    bus.bin = 1'b0;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    repeat (4) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL abort_ctrl: got busy %b done %b want 0 0", bus.busy, bus.done); end
    tests++; if (bus.diff !== 8'h00 || bus.bout !== 1'b0) begin fails++; $display("FAIL abort_data: got %h/%b want 00/0", bus.diff, bus.bout); end
    repeat (15) begin tick; seen += int'(bus.done); end
    tests++; if (seen != 0) begin fails++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
    do_op(8'hAA, 8'h55, 1'b0, d, bo, lat, bc, ok);
    tests++; if (d !== 8'h55 || bo !== 1'b0 || lat != 8) begin fails++; $display("FAIL abort_fresh: got %h/%b lat %0d want 55/0 8", d, bo, lat); end
  endtask
`ifdef SERIAL_SUB_SIGNED_EN
  task automatic test_signed;
    logic [7:0] va [3] = '{8'h80, 8'h7F, 8'h10};
    logic [7:0] vb [3] = '{8'h01, 8'hFF, 8'h05};
    logic [7:0] vd [3] = '{8'h7F, 8'h80, 8'h0B};
    logic vv [3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0] d; logic bo, ok; int lat, bc;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], 1'b0, d, bo, lat, bc, ok);
      tests++; if (d !== vd[i] || bus.ovf !== vv[i]) begin fails++; $display("FAIL signed_%0d: got %h ovf %b want %h ovf %b", i, d, bus.ovf, vd[i], vv[i]); end
    end
  endtask
`endif
  initial begin
    test_reset;
    test_basic;
    test_vectors;
    test_sweep;
    test_start_held;
    test_abort;
`ifdef SERIAL_SUB_SIGNED_EN
    test_signed;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
